// File: rtl/svc_rv_scoreboard.sv
// Register-pending scoreboard for long-latency producers.
// Stalls ID on RAW/WAW hazards against pending writes and on capacity.
module svc_rv_scoreboard #(
  parameter int XREGS           = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BYPASS_COMPLETE = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [4:0]                         rs1_id,
  input  logic [4:0]                         rs2_id,
  input  logic                               rs1_used_id,
  input  logic                               rs2_used_id,
  input  logic [4:0]                         rd_id,
  input  logic                               reg_write_id,
  input  logic                               issue_valid,
  input  logic                               issue_long,
  input  logic                               cmpl_valid,
  input  logic [4:0]                         cmpl_rd,
  input  logic                               flush,
  output logic                               stall,
  output logic [XREGS-1:0]                   pending,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               full
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  logic [XREGS-1:0] pending_q, pending_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_en, clr_en;
  logic             raw1, raw2, waw, cap;
  logic             byp1, byp2;

  assign set_en = issue_valid && issue_long
               && reg_write_id && (rd_id != 5'd0);
  assign clr_en = cmpl_valid && (cmpl_rd != 5'd0)
               && pending_q[cmpl_rd];

  assign full = (cnt_q == CW'(MAX_OUTSTANDING));

  // Same-cycle completion bypass only for readers; WAW keeps one extra cycle.
  assign byp1 = (BYPASS_COMPLETE != 0) && cmpl_valid
             && (cmpl_rd == rs1_id);
  assign byp2 = (BYPASS_COMPLETE != 0) && cmpl_valid
             && (cmpl_rd == rs2_id);

  assign raw1 = rs1_used_id && (rs1_id != 5'd0)
             && pending_q[rs1_id] && !byp1;
  assign raw2 = rs2_used_id && (rs2_id != 5'd0)
             && pending_q[rs2_id] && !byp2;
  assign waw  = reg_write_id && (rd_id != 5'd0)
             && pending_q[rd_id];
  assign cap  = issue_long && full && !cmpl_valid;

  assign stall       = raw1 | raw2 | waw | cap;
  assign pending     = pending_q;
  assign outstanding = cnt_q;

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (clr_en) pending_d[cmpl_rd] = 1'b0;
    if (set_en) pending_d[rd_id]   = 1'b1;
    case ({set_en, clr_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      pending_d = '0;
      cnt_d     = '0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && set_en && !clr_en)
      assert (!full);
  end

endmodule

// File: tb/tb_svc_rv_scoreboard.sv
// Directed bench for svc_rv_scoreboard, bypass and non-bypass variants.
// Expected values are queued at drive time and popped at check time.
module tb_svc_rv_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_id, rs2_id, rd_id, cmpl_rd;
  logic        rs1_used_id, rs2_used_id, reg_write_id;
  logic        issue_valid, issue_long, cmpl_valid, flush;
  logic        stall_b, stall_nb, full_b, full_nb;
  logic [31:0] pend_b, pend_nb;
  logic [2:0]  out_b, out_nb;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  svc_rv_scoreboard #(.BYPASS_COMPLETE(1)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .flush(flush), .stall(stall_b), .pending(pend_b),
    .outstanding(out_b), .full(full_b)
  );

  svc_rv_scoreboard #(.BYPASS_COMPLETE(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd),
    .flush(flush), .stall(stall_nb), .pending(pend_nb),
    .outstanding(out_nb), .full(full_nb)
  );

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL empty_queue observed=%h required=none", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic now(input string tag, input logic [31:0] obs,
                     input logic [31:0] v);
    push(tag, v);
    chk(obs);
  endtask

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_id = 0; cmpl_rd = 0;
    rs1_used_id = 0; rs2_used_id = 0; reg_write_id = 0;
    issue_valid = 0; issue_long = 0; cmpl_valid = 0;
    flush = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    issue_valid = 1; issue_long = 1;
    reg_write_id = 1; rd_id = r;
  endtask

  task automatic cmpl(input logic [4:0] r);
    cmpl_valid = 1; cmpl_rd = r;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    // reset state
    to_neg();
    now("rst_pending", pend_b, 32'h0);
    now("rst_outst", 32'(out_b), 32'd0);
    now("rst_full", 32'(full_b), 32'd0);
    now("rst_stall", 32'(stall_b), 32'd0);
    next();

    // cycle 1: long load to x5
    issue(5);
    to_neg();
    now("c1_stall", 32'(stall_b), 32'd0);
    push("c2_pending", 32'h20);
    push("c2_outst", 32'd1);
    next();
    // cycle 2: reader of x5
    rs1_id = 5; rs1_used_id = 1;
    to_neg();
    chk(pend_b);
    chk(32'(out_b));
    now("c2_stall", 32'(stall_b), 32'd1);
    now("c2_stall_nb", 32'(stall_nb), 32'd1);
    next();
    // cycle 3: completion of x5
    rs1_id = 5; rs1_used_id = 1; cmpl(5);
    to_neg();
    now("c3_stall", 32'(stall_b), 32'd0);
    now("c3_stall_nb", 32'(stall_nb), 32'd1);
    push("c4_pending", 32'h0);
    push("c4_outst", 32'd0);
    next();
    rs1_id = 5; rs1_used_id = 1;
    to_neg();
    chk(pend_b);
    chk(32'(out_b));
    now("c4_stall", 32'(stall_b), 32'd0);
    now("c4_stall_nb", 32'(stall_nb), 32'd0);
    next();

    // capacity: fill x1..x4
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i));
      next();
    end
    issue_long = 1; rd_id = 6; reg_write_id = 1;
    to_neg();
    now("cap_full", 32'(full_b), 32'd1);
    now("cap_outst", 32'(out_b), 32'd4);
    now("cap_stall", 32'(stall_b), 32'd1);
    next();
    issue(6); cmpl(2);
    to_neg();
    now("cap_cmpl_stall", 32'(stall_b), 32'd0);
    push("cap_after_outst", 32'd4);
    push("cap_after_pend", 32'h5a);
    next();
    to_neg();
    chk(32'(out_b));
    chk(pend_b);
    next();
    cmpl(1); next();
    cmpl(3); next();
    cmpl(4); next();
    cmpl(6);
    push("drain_outst", 32'd0);
    push("drain_full", 32'd0);
    next();
    to_neg();
    chk(32'(out_b));
    chk(32'(full_b));
    next();

    // same-cycle set and clear of x7
    issue(7);
    next();
    issue(7); cmpl(7);
    to_neg();
    now("waw_cmpl_stall", 32'(stall_b), 32'd1);
    push("x7_pend", 32'h80);
    push("x7_outst", 32'd1);
    next();
    rd_id = 7; reg_write_id = 1;
    to_neg();
    chk(pend_b);
    chk(32'(out_b));
    now("waw_stall", 32'(stall_b), 32'd1);
    next();
    rd_id = 7; reg_write_id = 1; cmpl(7);
    to_neg();
    now("waw_nosupp", 32'(stall_b), 32'd1);
    push("x7_clr_pend", 32'h0);
    next();
    to_neg();
    chk(pend_b);
    next();

    // x0 never tracked; spurious completion ignored
    issue(0);
    to_neg();
    now("x0_stall", 32'(stall_b), 32'd0);
    push("x0_pend", 32'h0);
    push("x0_outst", 32'd0);
    next();
    to_neg();
    chk(pend_b);
    chk(32'(out_b));
    next();
    issue(8);
    next();
    cmpl(9);
    push("spur_outst", 32'd1);
    push("spur_pend", 32'h100);
    next();
    to_neg();
    chk(32'(out_b));
    chk(pend_b);
    next();
    cmpl(8);
    next();

    // flush overrides same-cycle set/clear
    issue(10); next();
    issue(11); next();
    issue(12); next();
    rs2_id = 11; rs2_used_id = 1;
    to_neg();
    now("fl_pre_stall", 32'(stall_b), 32'd1);
    now("fl_pre_outst", 32'(out_b), 32'd3);
    next();
    rs2_id = 11; rs2_used_id = 1;
    flush = 1; issue(3); cmpl(10);
    to_neg();
    now("fl_cyc_stall", 32'(stall_b), 32'd1);
    push("fl_pend", 32'h0);
    push("fl_outst", 32'd0);
    next();
    rs2_id = 11; rs2_used_id = 1;
    to_neg();
    chk(pend_b);
    chk(32'(out_b));
    now("fl_stall", 32'(stall_b), 32'd0);
    now("fl_stall_nb", 32'(stall_nb), 32'd0);
    next();

    // reset mid-stall
    issue(13);
    next();
    rs1_id = 13; rs1_used_id = 1; rst = 1;
    to_neg();
    now("rs_cyc_stall", 32'(stall_b), 32'd1);
    push("rs_pend", 32'h0);
    push("rs_outst", 32'd0);
    push("rs_pend_nb", 32'h0);
    next();
    rst = 0;
    rs1_id = 13; rs1_used_id = 1;
    to_neg();
    chk(pend_b);
    chk(32'(out_b));
    chk(pend_nb);
    now("rs_stall", 32'(stall_b), 32'd0);
    next();

    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL queue_left observed=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
